// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;

  // Offset of the cycle counter within the MMIO window
  localparam logic [XLEN-1:0] MMIO_CYCLE_OFFSET = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU load/store port bundle
interface dmem_responder_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [BE_W-1:0] req_be;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 RAM, byte-enabled synchronous write, async read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [BE_W-1:0] i_be,
  input  logic [IW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [IW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);
  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (i_be[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store slave with fixed wait states and an MMIO cycle counter
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              DEPTH       = 64,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int              AW        = $clog2(4 * DEPTH);
  localparam int              IW        = AW - 2;
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(4 * DEPTH);
  localparam logic [XLEN-1:0] CYC_ADDR  = MMIO_BASE + MMIO_CYCLE_OFFSET;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [BE_W-1:0] r_be;
  logic [XLEN-1:0] r_cycle;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_enter_resp;
  logic [XLEN-1:0] w_dec_addr;
  logic            w_dec_write;
  logic            w_ram_hit;
  logic            w_mmio_hit;
  logic            w_err;
  logic            w_ram_we;
  logic            w_cyc_clr;
  logic [XLEN-1:0] w_ram_rdata;

  // With zero wait states IDLE goes straight to RESP, so decode the live request in IDLE
  assign w_dec_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_dec_write = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_ram_hit   = (w_dec_addr[1:0] == 2'b00) && (w_dec_addr < RAM_LIMIT);
  assign w_mmio_hit  = !w_ram_hit && (w_dec_addr == CYC_ADDR);
  assign w_err       = !w_ram_hit && !w_mmio_hit;

  assign w_accept     = (r_state == IDLE) && bus.req_valid;
  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
  assign w_ram_we     = (r_state == RESP) && r_write && w_ram_hit;
  assign w_cyc_clr    = (r_state == RESP) && r_write && w_mmio_hit;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (r_be),
    .i_waddr (r_addr[AW-1:2]),
    .i_wdata (r_wdata),
    .i_raddr (w_dec_addr[AW-1:2]),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cycle <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == WAIT && r_cnt != 4'd1) begin
        r_cnt <= r_cnt - 4'd1;
      end

      r_cycle <= w_cyc_clr ? '0 : r_cycle + 32'd1;

      // Counter loads report the value the counter holds during RESP, one past now
      if (w_enter_resp) begin
        r_err <= w_err;
        if (w_dec_write || w_err) r_rdata <= '0;
        else if (w_mmio_hit)      r_rdata <= r_cycle + 32'd1;
        else                      r_rdata <= w_ram_rdata;
      end else if (r_state == RESP) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
endmodule
